sbio_tx_arbiter: RTL and testbench

- Shares one sbio serial TX channel between N message requesters using round-robin arbitration.
- Frames each granted message on the wire: an all-low start cycle, then payload shifted LSB-first IO_BITS per cycle, then a guaranteed idle-high gap.
- Sits between the tester's message sources (run-mode schedule, cfg readback responses, status) and the registered output pad cells.

---
 rtl/sbio_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sbio_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbio_tx_arbiter.sv
// sbio_tx_arbiter: round-robin arbiter that shares one sbio serial TX channel
// between NUM_REQ message requesters. It frames each granted message as one
// all-low start cycle, then LSB-first payload (IO_BITS per cycle), then a
// forced idle-high gap.
//
// Optional build macro: SBIO_TX_ARB_PRIORITY0_EN
//   defined   -> requester 0 has strict priority and leaves the pointer alone
//   undefined -> pure round-robin over all requesters
module sbio_tx_arbiter #(
  parameter int IO_BITS       = 2,
  parameter int NUM_REQ       = 3,
  parameter int MAX_TX_CYCLES = 12,
  parameter int GAP_CYCLES    = 1,
  parameter int COUNT_BITS    = $clog2(MAX_TX_CYCLES + 1)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic [NUM_REQ-1:0]                        req,
  input  logic [NUM_REQ*IO_BITS*MAX_TX_CYCLES-1:0]  req_payload,
  input  logic [NUM_REQ*COUNT_BITS-1:0]             req_count,
  output logic [NUM_REQ-1:0]                        grant,
  output logic                                      busy,
  output logic [15:0]                               msg_sent,
  output logic [IO_BITS-1:0]                        tx_pins
);

  localparam int SR_W  = IO_BITS * MAX_TX_CYCLES;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_SEND,
    S_GAP
  } state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [SR_W-1:0]        shift_q, shift_d;
  logic [COUNT_BITS-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [15:0]            msg_q, msg_d;

  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W-1:0]       rr_idx;
  logic                   keep_ptr;
  logic [COUNT_BITS-1:0]  win_count;
  logic [COUNT_BITS-1:0]  win_count_clamped;

  // Winner search: first requester at or after the pointer, wrapping.
  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = '0;
    keep_ptr  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_idx = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!win_found && req[rr_idx]) begin
        win_found = 1'b1;
        win_idx   = rr_idx;
      end
    end
`ifdef SBIO_TX_ARB_PRIORITY0_EN
    // Requester 0 overrides the rotation and does not advance the pointer.
    if (req[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
      keep_ptr  = 1'b1;
    end
`endif
  end

  // Winner's data-cycle count, clamped to what the shift register holds.
  always_comb begin
    win_count         = req_count[int'(win_idx)*COUNT_BITS +: COUNT_BITS];
    win_count_clamped = (win_count > COUNT_BITS'(MAX_TX_CYCLES))
                        ? COUNT_BITS'(MAX_TX_CYCLES) : win_count;
  end

  // Frame FSM next-state logic: decision in IDLE, then START/SEND/GAP.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    grant_d = '0;
    msg_d   = msg_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable && win_found) begin
          shift_d = req_payload[int'(win_idx)*SR_W +: SR_W];
          cnt_d   = win_count_clamped;
          grant_d = NUM_REQ'(1) << win_idx;
          if (!keep_ptr) begin
            ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          end
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          gap_d   = GAP_W'(GAP_CYCLES - 1);
          msg_d   = msg_q + 16'd1;
        end else begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        shift_d = shift_q >> IO_BITS;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == COUNT_BITS'(1)) begin
          state_d = S_GAP;
          gap_d   = GAP_W'(GAP_CYCLES - 1);
          msg_d   = msg_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-high reset; aborts any frame.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      // NOTE: the payload shift register is reset too, so a reset mid-frame
      // leaves no stale message bits behind.
      shift_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      grant_q <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      msg_q   <= msg_d;
    end
  end

  // Wire driving: low for the start cycle, payload LSBs while sending, else high.
  always_comb begin
    tx_pins = '1;
    unique case (state_q)
      S_START: tx_pins = '0;
      S_SEND:  tx_pins = shift_q[IO_BITS-1:0];
      default: tx_pins = '1;
    endcase
  end

  assign grant    = grant_q;
  assign busy     = (state_q != S_IDLE);
  assign msg_sent = msg_q;

endmodule

// File: tb/tb_sbio_tx_arbiter.sv
// Directed testbench for sbio_tx_arbiter (default parameters).
module tb_sbio_tx_arbiter;

  localparam int IO_BITS = 2;
  localparam int NUM_REQ = 3;
  localparam int MAX_TX  = 12;
  localparam int GAP     = 1;
  localparam int CB      = 4;
  localparam int SR_W    = IO_BITS * MAX_TX;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      enable = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*SR_W-1:0]   req_payload = '0;
  logic [NUM_REQ*CB-1:0]     req_count = '0;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic [15:0]               msg_sent;
  logic [IO_BITS-1:0]        tx_pins;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sbio_tx_arbiter #(
    .IO_BITS(IO_BITS), .NUM_REQ(NUM_REQ), .MAX_TX_CYCLES(MAX_TX),
    .GAP_CYCLES(GAP), .COUNT_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .req_payload(req_payload), .req_count(req_count), .grant(grant),
    .busy(busy), .msg_sent(msg_sent), .tx_pins(tx_pins)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_msg(input int i, input logic [SR_W-1:0] p, input logic [CB-1:0] c);
    req_payload[i*SR_W +: SR_W] = p;
    req_count[i*CB +: CB]       = c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_grant(output int gcyc, output logic [NUM_REQ-1:0] g, output bit ok);
    ok = 1'b0; g = '0; gcyc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (grant != '0) begin
        g = grant; gcyc = cyc; ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; req = 3'b001;
    set_msg(0, 24'h0000E4, 4'd3);
    @(negedge clk);
    @(negedge clk);
    checks++; if (tx_pins !== 2'b11) begin errors++; $display("FAIL reset_tx: got %b expected 11", tx_pins); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (msg_sent !== 16'd0) begin errors++; $display("FAIL reset_msg_sent: got %0d expected 0", msg_sent); end
    req = '0; reset = 1'b0;
    @(negedge clk);
    checks++; if (tx_pins !== 2'b11 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got tx=%b busy=%b expected tx=11 busy=0", tx_pins, busy); end
  endtask

  task automatic test_single_frame();
    logic [1:0] exp_tx [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    bit         exp_bz [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    set_msg(0, 24'h0000E4, 4'd3);
    req = 3'b001;
    @(negedge clk);
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL single_grant: got %b expected 001", grant); end
    checks++; if (tx_pins !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL single_start: got tx=%b busy=%b expected tx=00 busy=1", tx_pins, busy); end
    req = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (tx_pins !== exp_tx[k] || busy !== exp_bz[k] || grant !== 3'b000) begin
        errors++;
        $display("FAIL single_seq[%0d]: got tx=%b busy=%b grant=%b expected tx=%b busy=%b grant=000",
                 k, tx_pins, busy, grant, exp_tx[k], exp_bz[k]);
      end
    end
    checks++; if (msg_sent !== 16'd1) begin errors++; $display("FAIL single_msg_sent: got %0d expected 1", msg_sent); end
  endtask

  task automatic run_rr(input string name, input logic [NUM_REQ-1:0] r,
                        input logic [NUM_REQ-1:0] e0, input logic [NUM_REQ-1:0] e1,
                        input logic [NUM_REQ-1:0] e2, input logic [NUM_REQ-1:0] e3);
    logic [NUM_REQ-1:0] exp_g [4];
    logic [NUM_REQ-1:0] g;
    int gcyc, prev;
    bit ok;
    exp_g[0] = e0; exp_g[1] = e1; exp_g[2] = e2; exp_g[3] = e3;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_msg(i, 24'h000001, 4'd1);
    req = r;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(gcyc, g, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL %s_timeout[%0d]: got no grant expected %b", name, k, exp_g[k]);
      end else if (g !== exp_g[k]) begin
        errors++; $display("FAIL %s_order[%0d]: got %b expected %b", name, k, g, exp_g[k]);
      end
      if (k > 0) begin
        checks++;
        if (gcyc - prev != 2 + 1 + GAP) begin
          errors++; $display("FAIL %s_spacing[%0d]: got %0d expected %0d", name, k, gcyc - prev, 2 + 1 + GAP);
        end
      end
      prev = gcyc;
    end
    req = '0;
    wait_idle(ok);
  endtask

  task automatic test_round_robin();
`ifdef SBIO_TX_ARB_PRIORITY0_EN
    run_rr("rr111", 3'b111, 3'b001, 3'b001, 3'b001, 3'b001);
`else
    run_rr("rr111", 3'b111, 3'b001, 3'b010, 3'b100, 3'b001);
`endif
  endtask

  task automatic test_two_requesters();
    run_rr("rr110", 3'b110, 3'b010, 3'b100, 3'b010, 3'b100);
  endtask

  task automatic test_count_edges();
    int n;
    do_reset();
    set_msg(0, 24'h0, 4'd0);
    req = 3'b001;
    @(negedge clk);
    checks++; if (grant !== 3'b001 || tx_pins !== 2'b00) begin errors++; $display("FAIL cnt0_start: got grant=%b tx=%b expected 001/00", grant, tx_pins); end
    req = '0;
    @(negedge clk);
    checks++; if (tx_pins !== 2'b11 || busy !== 1'b1 || msg_sent !== 16'd1) begin errors++; $display("FAIL cnt0_gap: got tx=%b busy=%b msg=%0d expected 11/1/1", tx_pins, busy, msg_sent); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cnt0_idle: got busy=%b expected 0", busy); end
    // Pointer now at 1; requester 1 asks for 15 cycles, which must clamp to 12.
    set_msg(1, 24'h0, 4'd15);
    req = 3'b010;
    @(negedge clk);
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL clamp_grant: got %b expected 010", grant); end
    req = '0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy && tx_pins == 2'b00) n++;
      else break;
    end
    checks++; if (n != MAX_TX) begin errors++; $display("FAIL clamp_len: got %0d data cycles expected %0d", n, MAX_TX); end
    checks++; if (tx_pins !== 2'b11 || busy !== 1'b1 || msg_sent !== 16'd2) begin errors++; $display("FAIL clamp_gap: got tx=%b busy=%b msg=%0d expected 11/1/2", tx_pins, busy, msg_sent); end
  endtask

  task automatic test_enable();
    int n;
    bit stray;
    bit ok;
    do_reset();
    set_msg(0, 24'h0, 4'd2);
    set_msg(1, 24'h0, 4'd1);
    enable = 1'b1; req = 3'b001;
    @(negedge clk);
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL en_first_grant: got %b expected 001", grant); end
    enable = 1'b0; req = 3'b010;
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    checks++; if (n != 2 + 2) begin errors++; $display("FAIL en_frame_len: got %0d busy cycles expected 4", n); end
    checks++; if (msg_sent !== 16'd1) begin errors++; $display("FAIL en_msg_sent: got %0d expected 1", msg_sent); end
    stray = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (grant != '0 || busy) stray = 1'b1;
    end
    checks++; if (stray) begin errors++; $display("FAIL en_hold: got activity while enable=0 expected none"); end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL en_resume_grant: got %b expected 010", grant); end
    req = '0;
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    set_msg(0, 24'h0, 4'd0);
    req = 3'b001;
    @(negedge clk);
    req = '0;
    wait_idle(ok);
    checks++; if (!ok || msg_sent !== 16'd1) begin errors++; $display("FAIL rst_pre_msg: got %0d expected 1", msg_sent); end
    set_msg(0, 24'h0, 4'd5);
    req = 3'b001;
    @(negedge clk);
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL rst_pre_grant: got %b expected 001", grant); end
    req = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || tx_pins !== 2'b00) begin errors++; $display("FAIL rst_send3: got busy=%b tx=%b expected 1/00", busy, tx_pins); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (tx_pins !== 2'b11 || busy !== 1'b0 || msg_sent !== 16'd0 || grant !== 3'b000) begin
      errors++; $display("FAIL rst_abort: got tx=%b busy=%b msg=%0d grant=%b expected 11/0/0/000", tx_pins, busy, msg_sent, grant);
    end
    reset = 1'b0; req = 3'b111;
    @(negedge clk);
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL rst_ptr: got %b expected 001", grant); end
    req = '0;
    wait_idle(ok);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_two_requesters();
    test_count_edges();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
